// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector with overlap control,
// a saturating match counter and a sticky saturation flag.
module seq_detector_param #(
  parameter int             PAT_W   = 7,
  parameter logic [PAT_W-1:0] PATTERN = 7'b0111110,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             i,
  input  logic             clr_cnt,
  output logic             w,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int FW = $clog2(PAT_W + 1);

  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W);
  localparam logic [FW-1:0] FILL_ARM = FW'(PAT_W - 1);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             w_q, w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic [PAT_W-1:0] win;
  logic             armed;
  logic             hit;
  logic             at_max;

  // Window as it will look once the incoming bit is shifted in.
  assign win    = {hist_q[PAT_W-2:0], i};
  assign armed  = fill_q >= FILL_ARM;
  assign hit    = en && armed && (win == PATTERN);
  assign at_max = &cnt_q;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (en) begin
      hist_d = win;
      if (hit && !OVERLAP) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FW'(1);
      end
    end
  end

  always_comb begin
    w_d = hit;
  end

  // Clear wins over increment, but a match on the clear edge counts.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr_cnt) begin
      cnt_d = hit ? CNT_W'(1) : '0;
      sat_d = 1'b0;
    end else if (hit) begin
      if (at_max) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      w_q    <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      w_q    <= w_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  assign w         = w_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomised and directed bench for seq_detector_param across four
// parameter sets, checked against a stream-based reference model.
module tb_seq_detector_param;

  logic clk;
  logic rst;
  logic en;
  logic i;
  logic clr_cnt;

  logic       w0, w1, w2, w3;
  logic [7:0] mc0, mc1, mc3;
  logic [1:0] mc2;
  logic       s0, s1, s2, s3;

  int n_chk = 0;
  int n_fail = 0;

  seq_detector_param u0 (
    .clk(clk), .rst(rst), .en(en), .i(i), .clr_cnt(clr_cnt),
    .w(w0), .match_cnt(mc0), .cnt_sat(s0)
  );

  seq_detector_param #(.OVERLAP(1'b0)) u1 (
    .clk(clk), .rst(rst), .en(en), .i(i), .clr_cnt(clr_cnt),
    .w(w1), .match_cnt(mc1), .cnt_sat(s1)
  );

  seq_detector_param #(.CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .i(i), .clr_cnt(clr_cnt),
    .w(w2), .match_cnt(mc2), .cnt_sat(s2)
  );

  seq_detector_param #(
    .PAT_W(3), .PATTERN(3'b111), .OVERLAP(1'b1)
  ) u3 (
    .clk(clk), .rst(rst), .en(en), .i(i), .clr_cnt(clr_cnt),
    .w(w3), .match_cnt(mc3), .cnt_sat(s3)
  );

  logic       w_a [4];
  logic [7:0] c_a [4];
  logic       s_a [4];

  assign w_a[0] = w0;
  assign w_a[1] = w1;
  assign w_a[2] = w2;
  assign w_a[3] = w3;
  assign c_a[0] = mc0;
  assign c_a[1] = mc1;
  assign c_a[2] = {6'd0, mc2};
  assign c_a[3] = mc3;
  assign s_a[0] = s0;
  assign s_a[1] = s1;
  assign s_a[2] = s2;
  assign s_a[3] = s3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: every enabled bit since reset, plus per-instance
  // index where the current search window may begin.
  int          pw   [4] = '{7, 7, 7, 3};
  logic [31:0] pat  [4] = '{32'b0111110, 32'b0111110,
                            32'b0111110, 32'b111};
  bit          ov   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int          cmax [4] = '{255, 255, 3, 255};

  bit s[$];
  int st [4];
  int cm [4];
  bit sm [4];
  bit wm [4];
  int pulses [4];

  task automatic model_clear();
    s.delete();
    for (int k = 0; k < 4; k++) begin
      st[k] = 0;
      cm[k] = 0;
      sm[k] = 1'b0;
      wm[k] = 1'b0;
      pulses[k] = 0;
    end
  endtask

  task automatic step(input logic e, input logic b, input logic c);
    bit mt;
    int n;
    en = e;
    i = b;
    clr_cnt = c;
    @(posedge clk);
    if (e) s.push_back(b);
    n = s.size();
    for (int k = 0; k < 4; k++) begin
      mt = 1'b0;
      if (e && (n - st[k] >= pw[k])) begin
        mt = 1'b1;
        for (int j = 0; j < pw[k]; j++)
          if (s[n - pw[k] + j] != pat[k][pw[k] - 1 - j]) mt = 1'b0;
      end
      if (mt && !ov[k]) st[k] = n;
      wm[k] = mt;
      if (c) begin
        cm[k] = mt ? 1 : 0;
        sm[k] = 1'b0;
      end else if (mt) begin
        if (cm[k] == cmax[k]) sm[k] = 1'b1;
        else cm[k] = cm[k] + 1;
      end
    end
    #1;
    for (int k = 0; k < 4; k++) if (w_a[k] === 1'b1) pulses[k]++;
  endtask

  task automatic feed(input string b);
    for (int j = 0; j < b.len(); j++)
      step(1'b1, b[j] == 8'h31, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (w_a[k] !== 1'b0 || c_a[k] !== 8'd0 || s_a[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset inst%0d: w=%b cnt=%0d sat=%b want 0/0/0",
                 k, w_a[k], c_a[k], s_a[k]);
      end
    end
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b0;
    i = 1'b0;
    clr_cnt = 1'b0;
    rst = 1'b0;
    #1;
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    feed("011111");
    n_chk++;
    if (w_a[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: w=%b want 0", w_a[0]);
    end
    feed("0");
    n_chk++;
    if (w_a[0] !== 1'b1 || c_a[0] !== 8'd1) begin
      n_fail++;
      $display("FAIL single_hit: w=%b cnt=%0d want 1/1", w_a[0], c_a[0]);
    end
    step(1'b1, 1'b1, 1'b0);
    n_chk++;
    if (w_a[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pulse_width: w=%b want 0", w_a[0]);
    end
  endtask

  task automatic test_overlap();
    do_reset();
    feed("0111110111110");
    n_chk++;
    if (pulses[0] !== 2 || c_a[0] !== 8'd2) begin
      n_fail++;
      $display("FAIL overlap_on: pulses=%0d cnt=%0d want 2/2",
               pulses[0], c_a[0]);
    end
    n_chk++;
    if (pulses[1] !== 1 || c_a[1] !== 8'd1) begin
      n_fail++;
      $display("FAIL overlap_off: pulses=%0d cnt=%0d want 1/1",
               pulses[1], c_a[1]);
    end
  endtask

  task automatic test_no_match();
    do_reset();
    feed("01111110");
    n_chk++;
    if (pulses[0] !== 0 || c_a[0] !== 8'd0) begin
      n_fail++;
      $display("FAIL six_ones: pulses=%0d cnt=%0d want 0/0",
               pulses[0], c_a[0]);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    feed("011");
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      n_chk++;
      if (w_a[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_w: w=%b want 0", w_a[0]);
      end
    end
    feed("11");
    step(1'b0, 1'b0, 1'b0);
    feed("1");
    step(1'b0, 1'b1, 1'b0);
    n_chk++;
    if (w_a[0] !== 1'b0 || c_a[0] !== 8'd0) begin
      n_fail++;
      $display("FAIL gap_pre: w=%b cnt=%0d want 0/0", w_a[0], c_a[0]);
    end
    feed("0");
    n_chk++;
    if (w_a[0] !== 1'b1 || c_a[0] !== 8'd1 || pulses[0] !== 1) begin
      n_fail++;
      $display("FAIL gap_hit: w=%b cnt=%0d pulses=%0d want 1/1/1",
               w_a[0], c_a[0], pulses[0]);
    end
  endtask

  task automatic test_sat();
    do_reset();
    for (int r = 0; r < 4; r++) feed("0111110");
    n_chk++;
    if (c_a[2] !== 8'd3 || s_a[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_reach: cnt=%0d sat=%b want 3/1", c_a[2], s_a[2]);
    end
    n_chk++;
    if (c_a[0] !== 8'd4 || s_a[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_wide: cnt=%0d sat=%b want 4/0", c_a[0], s_a[0]);
    end
    feed("011111");
    step(1'b1, 1'b0, 1'b1);
    n_chk++;
    if (c_a[2] !== 8'd1 || s_a[2] !== 1'b0 || w_a[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_on_match: cnt=%0d sat=%b w=%b want 1/0/1",
               c_a[2], s_a[2], w_a[2]);
    end
    step(1'b0, 1'b0, 1'b1);
    n_chk++;
    if (c_a[0] !== 8'd0 || c_a[2] !== 8'd0 || w_a[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_no_en: cnt0=%0d cnt2=%0d w=%b want 0/0/0",
               c_a[0], c_a[2], w_a[0]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    feed("0111");
    do_reset();
    feed("110");
    n_chk++;
    if (c_a[0] !== 8'd0 || pulses[0] !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_partial: cnt=%0d pulses=%0d want 0/0",
               c_a[0], pulses[0]);
    end
    feed("0111110");
    n_chk++;
    if (c_a[0] !== 8'd1 || pulses[0] !== 1) begin
      n_fail++;
      $display("FAIL reset_mid_full: cnt=%0d pulses=%0d want 1/1",
               c_a[0], pulses[0]);
    end
  endtask

  task automatic test_back_to_back();
    int run;
    int best;
    run = 0;
    best = 0;
    do_reset();
    for (int j = 0; j < 5; j++) begin
      step(1'b1, 1'b1, 1'b0);
      run = (w_a[3] === 1'b1) ? run + 1 : 0;
      if (run > best) best = run;
    end
    n_chk++;
    if (best !== 3 || c_a[3] !== 8'd3) begin
      n_fail++;
      $display("FAIL back_to_back: run=%0d cnt=%0d want 3/3", best, c_a[3]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             $urandom_range(0, 49) == 0);
        for (int k = 0; k < 4; k++) begin
          n_chk++;
          if (w_a[k] !== wm[k] || c_a[k] !== 8'(cm[k])
              || s_a[k] !== sm[k]) begin
            n_fail++;
            $display("FAIL random inst%0d step%0d: w=%b cnt=%0d sat=%b want %b/%0d/%b",
                     k, n, w_a[k], c_a[k], s_a[k], wm[k], cm[k], sm[k]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overlap();
    test_no_match();
    test_gaps();
    test_sat();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
